// File: rtl/traffic_ctrl_n_pkg.sv
// Shared definitions for the N-way traffic controller: phase codes and
// width helpers used to size the approach index.
package traffic_ctrl_n_pkg;

  // Phase codes as seen on the phase output.
  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Approach index width; never narrower than one bit.
  function automatic int dirw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/traffic_ctrl_n_if.sv
// Sensor/lamp bundle between the sensor side (master) and the controller (slave).
interface traffic_ctrl_n_if #(
  parameter int NUM_DIR = 2
);
  import traffic_ctrl_n_pkg::*;

  localparam int DIRW = dirw(NUM_DIR);

  logic [NUM_DIR-1:0] req;     // level vehicle-present, one bit per approach
  logic [NUM_DIR-1:0] green;   // one-hot or zero
  logic [NUM_DIR-1:0] yellow;  // one-hot or zero
  logic [NUM_DIR-1:0] red;     // ~(green | yellow)
  logic [DIRW-1:0]    active;  // approach holding right-of-way
  phase_e             phase;

  modport master (output req, input green, yellow, red, active, phase);
  modport slave  (input req, output green, yellow, red, active, phase);

endinterface

// File: rtl/traffic_ctrl_n_rr_pick.sv
// Round-robin picker: first requesting approach after the active one,
// scanning active+1, active+2, ... with wrap, the active approach excluded.
// valid doubles as "some other approach is waiting".
module traffic_ctrl_n_rr_pick #(
  parameter int NUM_DIR = 2,
  parameter int DIRW    = 1
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [DIRW-1:0]    active,
  output logic [DIRW-1:0]    pick,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      if (req[(int'(active) + k) % NUM_DIR]) begin
        pick  = DIRW'((int'(active) + k) % NUM_DIR);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-way timed traffic-light controller: green (min / sensor-extended max),
// yellow, all-red clearance, round-robin hand-over between approaches.
// Lamps decode registered state only; req never reaches an output directly.
module traffic_ctrl_n
  import traffic_ctrl_n_pkg::*;
#(
  parameter int NUM_DIR   = 2,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YEL_CYC   = 4,
  parameter int AR_CYC    = 2,
  parameter int TW        = 8
) (
  input logic            clk,
  input logic            rst,
  traffic_ctrl_n_if.slave bus
);

  localparam int DIRW = dirw(NUM_DIR);

  phase_e              phase_q, phase_d;
  logic [TW-1:0]       timer_q;
  logic [DIRW-1:0]     active_q, active_d;
  logic [DIRW-1:0]     target_q, target_d;

  logic [NUM_DIR-1:0]  own_mask;
  logic                own_req;
  logic                other;
  logic [DIRW-1:0]     pick;

  logic                min_ok, max_hit, ar_done, yel_done;
  logic [NUM_DIR-1:0]  green, yellow;

  traffic_ctrl_n_rr_pick #(
    .NUM_DIR (NUM_DIR),
    .DIRW    (DIRW)
  ) u_rr (
    .req    (bus.req),
    .active (active_q),
    .pick   (pick),
    .valid  (other)
  );

  assign own_mask = NUM_DIR'(1) << active_q;
  assign own_req  = |(bus.req & own_mask);

  // Timer holds cycles already spent in the phase, so "N cycles" ends at N-1.
  assign min_ok   = timer_q >= TW'(MIN_GREEN - 1);
  assign max_hit  = timer_q >= TW'(MAX_GREEN - 1);
  assign ar_done  = timer_q >= TW'(AR_CYC - 1);
  assign yel_done = timer_q >= TW'(YEL_CYC - 1);

  // State register: phase, timer, owner and the latched next owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_ALL_RED;
      timer_q  <= '0;
      active_q <= '0;
      target_q <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      target_q <= target_d;
      if (phase_d != phase_q)
        timer_q <= '0;
      else if (timer_q < TW'(MAX_GREEN))
        timer_q <= timer_q + TW'(1);
    end
  end

  // Next-state: own sensor only extends green while others wait, up to max.
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    target_d = target_q;
    case (phase_q)
      PH_ALL_RED: begin
        if (ar_done) begin
          phase_d  = PH_GREEN;
          active_d = target_q;
        end
      end
      PH_GREEN: begin
        if (min_ok && other && (!own_req || max_hit)) begin
          phase_d  = PH_YELLOW;
          target_d = pick;   // frozen here; later req changes are ignored
        end
      end
      PH_YELLOW: begin
        if (yel_done) phase_d = PH_ALL_RED;
      end
      default: phase_d = PH_ALL_RED;
    endcase
  end

  // Lamp decode from registered phase and owner.
  always_comb begin
    green  = '0;
    yellow = '0;
    case (phase_q)
      PH_GREEN:  green  = own_mask;
      PH_YELLOW: yellow = own_mask;
      default:   ;
    endcase
  end

  assign bus.green  = green;
  assign bus.yellow = yellow;
  assign bus.red    = ~(green | yellow);
  assign bus.active = active_q;
  assign bus.phase  = phase_q;

endmodule
